gpu_dma_port_master: RTL

- DMA channel-2 initiator that drives the GPU CPU-side port: gpuSel/write/read strobes, A2 address bit, 32-bit write data.
- To-GPU mode: streams words from a memory-side source into GP0.
- From-GPU mode: issues GPUREAD reads and captures returned data, which is valid one cycle after the read strobe, into a memory-side sink.
- Sits between the DMA arbiter and the GPU frontend. Owns no GPU registers.

---
 rtl/gpu_dma_pkg.sv | 9 +
 rtl/gpu_dma_port_master_if.sv | 26 ++
 rtl/gpu_dma_skid.sv | 26 ++
 rtl/gpu_dma_port_master.sv | 96 +++++++++
 4 files changed

// File: rtl/gpu_dma_pkg.sv
// gpu_dma_pkg: shared state, direction and address definitions for the GPU DMA port master
package gpu_dma_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {DMA_DirOff, FIFO, CPUtoGP0, GPUREADtoCPU} dma_direction_t;
  localparam logic GPU_A2_GP0 = 1'b0;
  function automatic dma_direction_t dir_of(input logic dir_to_gpu);
    return dir_to_gpu ? CPUtoGP0 : GPUREADtoCPU;
  endfunction
endpackage

// File: rtl/gpu_dma_port_master_if.sv
// gpu_dma_port_master_if: memory-side source/sink streams and the GPU CPU-side port
interface gpu_dma_port_master_if;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] dst_data;
  logic        dst_valid;
  logic        dst_ready;
  logic        gpu_sel;
  logic        gpu_adr_a2;
  logic        write;
  logic        read;
  logic [31:0] gpu_data_in;
  logic [31:0] gpu_data_out;
  logic        gpu_data_out_valid;
  logic        gpu_dma_req;
  logic        gpu_read_ready;
  modport master (
    input  src_data, src_valid, dst_ready, gpu_data_out, gpu_data_out_valid, gpu_dma_req, gpu_read_ready,
    output src_ready, dst_data, dst_valid, gpu_sel, gpu_adr_a2, write, read, gpu_data_in
  );
  modport slave (
    output src_data, src_valid, dst_ready, gpu_data_out, gpu_data_out_valid, gpu_dma_req, gpu_read_ready,
    input  src_ready, dst_data, dst_valid, gpu_sel, gpu_adr_a2, write, read, gpu_data_in
  );
endinterface

// File: rtl/gpu_dma_skid.sv
// gpu_dma_skid: one-entry valid/ready holding buffer for GPUREAD words headed to memory
module gpu_dma_skid #(parameter int DW = 32) (
  input  logic          i_clk,
  input  logic          i_nRst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  // load wins: the master only loads when the entry is empty
  always_ff @(posedge i_clk or negedge i_nRst)
    if (!i_nRst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid & i_ready) begin
      r_valid <= 1'b0;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/gpu_dma_port_master.sv
// gpu_dma_port_master: DMA channel-2 initiator for the GPU port; GPU_DMA_ABORT_EN adds i_abort/o_aborted/o_remaining
module gpu_dma_port_master
  import gpu_dma_pkg::*;
#(parameter int CNT_W = 16) (
  input  logic             i_clk,
  input  logic             i_nRst,
  input  logic             i_start,
  input  logic             i_dirToGPU,
  input  logic [CNT_W-1:0] i_wordCount,
  output logic             o_busy,
  output logic             o_done,
`ifdef GPU_DMA_ABORT_EN
  input  logic             i_abort,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_remaining,
`endif
  gpu_dma_port_master_if.master bus
);
  typedef logic [CNT_W:0] rem_t;
  state_t r_state, w_next;
  rem_t   r_remaining, w_rem_nxt;
  logic   w_wr_hs, w_rd_issue, w_cap, w_skid_valid, w_last, w_abort;
  assign w_last = r_remaining == rem_t'(1);
`ifdef GPU_DMA_ABORT_EN
  logic r_abort;
  // abort request is held until the transfer has wound down through DONE
  always_ff @(posedge i_clk or negedge i_nRst)
    if (!i_nRst) r_abort <= 1'b0;
    else r_abort <= ((r_state inside {S_WRITE, S_READ, S_RDWAIT}) & i_abort) | (r_abort & (r_state != S_DONE) & (r_state != S_IDLE));
  assign w_abort     = r_abort | i_abort;
  assign o_aborted   = (r_state == S_DONE) & r_abort;
  assign o_remaining = r_remaining[CNT_W-1:0];
`else
  assign w_abort = 1'b0;
`endif
  // state and word counter registers
  always_ff @(posedge i_clk or negedge i_nRst)
    if (!i_nRst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_rem_nxt;
    end
  // next-state, counter update and strobe decode
  always_comb begin
    w_next     = r_state;
    w_rem_nxt  = r_remaining;
    w_wr_hs    = 1'b0;
    w_rd_issue = 1'b0;
    w_cap      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_next    = (dir_of(i_dirToGPU) == CPUtoGP0) ? S_WRITE : S_READ;
        w_rem_nxt = (i_wordCount == '0) ? rem_t'(1) << CNT_W : rem_t'(i_wordCount);
      end
      S_WRITE: if (w_abort) w_next = S_DONE;
      else if (bus.src_valid & bus.gpu_dma_req) begin
        w_wr_hs   = 1'b1;
        w_rem_nxt = r_remaining - rem_t'(1);
        w_next    = w_last ? S_DONE : S_WRITE;
      end
      S_READ: if (w_abort) w_next = S_DRAIN;
      else if (bus.gpu_read_ready & ~w_skid_valid) begin
        w_rd_issue = 1'b1;
        w_next     = S_RDWAIT;
      end
      S_RDWAIT: if (bus.gpu_data_out_valid) begin
        w_cap     = 1'b1;
        w_rem_nxt = r_remaining - rem_t'(1);
        w_next    = (w_last | w_abort) ? S_DRAIN : S_READ;
      end
      S_DRAIN: w_next = (~w_skid_valid | bus.dst_ready) ? S_DONE : S_DRAIN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  assign o_busy          = r_state != S_IDLE;
  assign o_done          = r_state == S_DONE;
  assign bus.src_ready   = w_wr_hs;
  assign bus.write       = w_wr_hs;
  assign bus.read        = w_rd_issue;
  assign bus.gpu_sel     = w_wr_hs | w_rd_issue;
  assign bus.gpu_adr_a2  = GPU_A2_GP0;
  assign bus.gpu_data_in = w_wr_hs ? bus.src_data : 32'h0;
  assign bus.dst_valid   = w_skid_valid;
  gpu_dma_skid #(.DW(32)) u_skid (
    .i_clk   (i_clk),
    .i_nRst  (i_nRst),
    .i_valid (w_cap),
    .i_data  (bus.gpu_data_out),
    .i_ready (bus.dst_ready),
    .o_valid (w_skid_valid),
    .o_data  (bus.dst_data)
  );
endmodule
